dma_bus_ctrl: RTL and testbench

OAM DMA controller and main-bus arbiter between the CPU core and the external memory bus. Owns the DMA source register at 0xFF46. A write to it copies 160 bytes from {src,8'h00}..{src,8'h9F} to 0xFE00..0xFE9F, one byte per M-cycle. Sequencing is locked to the decode block's t_cycle. While the DMA runs, the block denies the CPU the main bus and keeps the 0xFFxx page (I/O, HRAM) reachable through a separate high-page port.

---
 rtl/dma_bus_ctrl.sv | 90 +++++++++
 tb/tb_dma_bus_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_ctrl.sv
// dma_bus_ctrl: OAM DMA engine (FF46) and main-bus arbiter between the CPU and external memory.
// DMA owns the main bus while active; the FFxx page stays reachable through the hi_* port.
module dma_bus_ctrl (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  t_cycle_i,
    input  logic [15:0] cpu_addr_i,
    input  logic        cpu_rd_i,
    input  logic        cpu_wr_i,
    input  logic [7:0]  cpu_wdata_i,
    output logic [7:0]  cpu_rdata_o,
    output logic        cpu_blocked_o,
    output logic [15:0] bus_addr_o,
    output logic        bus_rd_o,
    output logic        bus_wr_o,
    output logic [7:0]  bus_wdata_o,
    input  logic [7:0]  bus_rdata_i,
    output logic [7:0]  hi_addr_o,
    output logic        hi_rd_o,
    output logic        hi_wr_o,
    output logic [7:0]  hi_wdata_o,
    input  logic [7:0]  hi_rdata_i,
    output logic        dma_active_o
);
    typedef enum logic [1:0] {IDLE, START, XFER} state_t;

    state_t      state_q;
    logic [7:0]  src_q;
    logic [7:0]  idx_q;
    logic [7:0]  latch_q;

    logic is_ff46, trig, t2, t3, xfer, act, main_pg, hi_pg, cpu_bus;
    logic [7:0] eff;

    assign is_ff46 = cpu_addr_i == 16'hFF46;
    assign t2      = t_cycle_i == 2'd2;
    assign t3      = t_cycle_i == 2'd3;
    assign trig    = cpu_wr_i && is_ff46 && t3;
    assign xfer    = state_q == XFER;
    assign act     = state_q != IDLE;
    assign main_pg = cpu_addr_i[15:8] != 8'hFF;
    assign hi_pg   = rst_ni && !main_pg && !is_ff46;
    assign cpu_bus = rst_ni && !act && main_pg;
    // Echo RAM E000-FDFF mirrors C000-DDFF
    assign eff     = src_q >= 8'hE0 ? src_q - 8'h20 : src_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            src_q   <= 8'h00;
            idx_q   <= 8'h00;
            latch_q <= 8'h00;
        end else if (trig) begin
            state_q <= START;
            src_q   <= cpu_wdata_i;
            idx_q   <= 8'h00;
        end else begin
            case (state_q)
                START: if (t3) state_q <= XFER;
                XFER: begin
                    if (t2) latch_q <= bus_rdata_i;
                    if (t3) begin
                        idx_q   <= idx_q == 8'd159 ? 8'h00 : idx_q + 8'h01;
                        state_q <= idx_q == 8'd159 ? IDLE : XFER;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dma_active_o  = act;
    assign cpu_blocked_o = rst_ni && act && main_pg && (cpu_rd_i || cpu_wr_i);
    assign bus_addr_o    = !rst_ni ? 16'h0000 :
                           xfer    ? (t3 ? {8'hFE, idx_q} : {eff, idx_q}) :
                           cpu_bus ? cpu_addr_i : 16'h0000;
    assign bus_rd_o      = rst_ni && (xfer ? t2 : cpu_bus && cpu_rd_i);
    assign bus_wr_o      = rst_ni && (xfer ? t3 : cpu_bus && cpu_wr_i);
    assign bus_wdata_o   = !rst_ni ? 8'h00 :
                           xfer    ? (t3 ? latch_q : 8'h00) :
                           cpu_bus ? cpu_wdata_i : 8'h00;
    assign hi_addr_o     = hi_pg ? cpu_addr_i[7:0] : 8'h00;
    assign hi_rd_o       = hi_pg && cpu_rd_i;
    assign hi_wr_o       = hi_pg && cpu_wr_i;
    assign hi_wdata_o    = hi_pg ? cpu_wdata_i : 8'h00;
    assign cpu_rdata_o   = !rst_ni ? 8'hFF :
                           is_ff46 ? src_q :
                           hi_pg   ? hi_rdata_i :
                           cpu_bus ? bus_rdata_i : 8'hFF;
endmodule

// File: tb/tb_dma_bus_ctrl.sv
// tb_dma_bus_ctrl: directed bench with a write scoreboard for OAM DMA traffic.
module tb_dma_bus_ctrl;
    logic        clk = 0, rst_n = 0;
    logic [1:0]  t_cycle = 0;
    logic [15:0] cpu_addr = 0;
    logic        cpu_rd = 0, cpu_wr = 0;
    logic [7:0]  cpu_wdata = 0;
    logic [7:0]  cpu_rdata;
    logic        cpu_blocked;
    logic [15:0] bus_addr;
    logic        bus_rd, bus_wr;
    logic [7:0]  bus_wdata, bus_rdata;
    logic [7:0]  hi_addr;
    logic        hi_rd, hi_wr;
    logic [7:0]  hi_wdata;
    logic [7:0]  hi_rdata = 8'hA7;
    logic        dma_active;

    int vectors = 0, miscompares = 0, wr_cnt = 0, act_cnt = 0;
    logic [23:0] exp_q[$];

    dma_bus_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .t_cycle_i(t_cycle),
        .cpu_addr_i(cpu_addr), .cpu_rd_i(cpu_rd), .cpu_wr_i(cpu_wr),
        .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_blocked_o(cpu_blocked),
        .bus_addr_o(bus_addr), .bus_rd_o(bus_rd), .bus_wr_o(bus_wr),
        .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata),
        .hi_addr_o(hi_addr), .hi_rd_o(hi_rd), .hi_wr_o(hi_wr),
        .hi_wdata_o(hi_wdata), .hi_rdata_i(hi_rdata), .dma_active_o(dma_active)
    );

    function automatic logic [7:0] mem(input logic [15:0] a);
        logic [7:0] m;
        m = a[7:0] * 8'd3;
        return m ^ a[15:8];
    endfunction

    assign bus_rdata = mem(bus_addr);

    always #5 clk = ~clk;
    always @(posedge clk) t_cycle <= t_cycle + 2'd1;

    always @(negedge clk) begin
        logic [23:0] e;
        if (dma_active) act_cnt++;
        if (bus_wr) begin
            vectors++;
            wr_cnt++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_wr got %h/%h expected none", bus_addr, bus_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({bus_addr, bus_wdata} !== e) begin
                    miscompares++;
                    $display("FAIL oam_wr got %h/%h expected %h/%h", bus_addr, bus_wdata, e[23:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic to_t(input logic [1:0] k);
        do begin @(posedge clk); #1; end while (t_cycle != k);
    endtask

    task automatic push_copy(input logic [7:0] page);
        for (int i = 0; i < 160; i++) begin
            logic [7:0] ix;
            ix = 8'(i);
            exp_q.push_back({8'hFE, ix, mem({page, ix})});
        end
    endtask

    task automatic trigger(input logic [7:0] v);
        cpu_addr = 16'hFF46; cpu_wdata = v; cpu_wr = 1;
        @(posedge clk);
        act_cnt = 0;
        #1 cpu_wr = 0; cpu_addr = 16'h0000;
    endtask

    task automatic wait_wr(input int n);
        int b = 0;
        while (wr_cnt < n && b < 5000) begin @(negedge clk); b++; end
        chk("wait_wr", wr_cnt >= n, 1);
    endtask

    task automatic wait_idle();
        int b = 0;
        while (dma_active && b < 5000) begin @(negedge clk); b++; end
        chk("wait_idle", dma_active, 0);
    endtask

    initial begin
        int n;
        cpu_addr = 16'h1234; cpu_rd = 1;
        #12;
        chk("rst_bus_rd", bus_rd, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_cpu_rdata", cpu_rdata, 8'hFF);
        chk("rst_active", dma_active, 0);
        chk("rst_blocked", cpu_blocked, 0);
        cpu_rd = 0;
        @(posedge clk); #1 rst_n = 1;

        cpu_addr = 16'h1234; cpu_rd = 1; #1;
        chk("idle_addr", bus_addr, 16'h1234);
        chk("idle_rd", bus_rd, 1);
        chk("idle_rdata", cpu_rdata, mem(16'h1234));
        chk("idle_blocked", cpu_blocked, 0);
        cpu_rd = 0;

        wr_cnt = 0;
        push_copy(8'hC0);
        to_t(3);
        trigger(8'hC0);
        n = 0;
        while (!bus_wr && n < 20) begin @(negedge clk); n++; end
        chk("first_wr_lat", n, 8);
        wait_wr(30);
        to_t(1);
        cpu_addr = 16'h8000; cpu_rd = 1; #1;
        chk("blk_rdata", cpu_rdata, 8'hFF);
        chk("blk_blocked", cpu_blocked, 1);
        chk("blk_bus_addr", bus_addr, 16'hC01E);
        cpu_rd = 0; cpu_addr = 16'hFF80; cpu_wdata = 8'h5A; cpu_wr = 1; #1;
        chk("hi_wr", hi_wr, 1);
        chk("hi_addr", hi_addr, 8'h80);
        chk("hi_wdata", hi_wdata, 8'h5A);
        chk("hi_blocked", cpu_blocked, 0);
        cpu_wr = 0; cpu_rd = 1; #1;
        chk("hi_rdata", cpu_rdata, 8'hA7);
        cpu_rd = 0;
        wait_idle();
        chk("active_clocks", act_cnt, 644);
        chk("wr_count", wr_cnt, 160);
        chk("queue_empty", exp_q.size(), 0);

        wr_cnt = 0;
        push_copy(8'hD1);
        to_t(3);
        trigger(8'hF1);
        cpu_addr = 16'hFF46; cpu_rd = 1; #1;
        chk("ff46_read", cpu_rdata, 8'hF1);
        chk("ff46_hi_rd", hi_rd, 0);
        cpu_rd = 0;
        wait_idle();
        chk("echo_wr_count", wr_cnt, 160);

        wr_cnt = 0;
        push_copy(8'h10);
        to_t(3);
        trigger(8'h10);
        wait_wr(50);
        to_t(3);
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        push_copy(8'h80);
        trigger(8'h80);
        wait_idle();
        chk("retrig_active", act_cnt, 644);
        chk("retrig_wr_count", wr_cnt, 211);

        wr_cnt = 0;
        push_copy(8'h30);
        to_t(3);
        trigger(8'h30);
        wait_wr(20);
        to_t(1);
        #2 rst_n = 0; #1;
        chk("mid_rst_active", dma_active, 0);
        chk("mid_rst_bus_addr", bus_addr, 0);
        chk("mid_rst_bus_rd", bus_rd, 0);
        chk("mid_rst_bus_wr", bus_wr, 0);
        chk("mid_rst_rdata", cpu_rdata, 8'hFF);
        exp_q.delete();
        repeat (8) @(negedge clk);
        @(posedge clk); #1 rst_n = 1;
        repeat (20) @(negedge clk);
        chk("post_rst_wr_count", wr_cnt, 20);
        chk("post_rst_active", dma_active, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
